// File: rtl/mul_uart_sequencer.sv
// Command sequencer: two UART bytes -> 8x8 multiply -> two UART bytes (product high, then low).
// Optional inter-byte timeout in GET_B is enabled by defining MUL_SEQ_TIMEOUT_EN.
module mul_uart_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        mul_start,
  output logic [15:0] mul_ip_BA,
  input  logic [15:0] mul_op_prod,
  input  logic        mul_ready,
  output logic        busy,
  output logic        err_overrun
);

  typedef enum logic [2:0] {
    S_GET_A   = 3'd0,
    S_GET_B   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SEND_HI = 3'd4,
    S_SEND_LO = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_a;
  logic [15:0] r_ba;
  logic [15:0] r_prod;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_mul_start;
  logic        r_busy;
  logic        r_err;

  logic        w_load_a;
  logic        w_load_b;
  logic        w_capture;
  logic        w_drop;
  logic        w_timeout;
  logic [7:0]  w_tx_data;

`ifdef MUL_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_state == S_GET_B) && !rx_valid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter: cleared entering GET_B, counts idle GET_B cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_load_a || w_timeout) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_GET_B) && !rx_valid) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode and datapath load enables.
  always_comb begin
    w_next    = r_state;
    w_load_a  = 1'b0;
    w_load_b  = 1'b0;
    w_capture = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      S_GET_A: begin
        if (rx_valid) begin
          w_load_a = 1'b1;
          w_next   = S_GET_B;
        end else begin
          w_next = S_GET_A;
        end
      end
      S_GET_B: begin
        if (rx_valid) begin
          w_load_b = 1'b1;
          w_next   = S_START;
        end else if (w_timeout) begin
          w_next = S_GET_A;
        end else begin
          w_next = S_GET_B;
        end
      end
      S_START: begin
        w_drop = rx_valid;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_drop = rx_valid;
        if (mul_ready) begin
          w_capture = 1'b1;
          w_next    = S_SEND_HI;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_SEND_HI: begin
        w_drop = rx_valid;
        if (tx_ready) begin
          w_next = S_SEND_LO;
        end else begin
          w_next = S_SEND_HI;
        end
      end
      S_SEND_LO: begin
        w_drop = rx_valid;
        if (tx_ready) begin
          w_next = S_GET_A;
        end else begin
          w_next = S_SEND_LO;
        end
      end
      default: begin
        w_next = S_GET_A;
      end
    endcase
  end

  // The high byte must come straight from the multiplier on the capture cycle.
  always_comb begin
    w_tx_data = 8'h00;
    case (w_next)
      S_SEND_HI: begin
        if (w_capture) begin
          w_tx_data = mul_op_prod[15:8];
        end else begin
          w_tx_data = r_prod[15:8];
        end
      end
      S_SEND_LO: begin
        w_tx_data = r_prod[7:0];
      end
      default: begin
        w_tx_data = 8'h00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_GET_A;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand and product registers; operands persist after the transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= 8'h00;
      r_ba   <= 16'h0000;
      r_prod <= 16'h0000;
    end else begin
      if (w_load_a) begin
        r_a <= rx_data;
      end
      if (w_load_b) begin
        r_ba <= {rx_data, r_a};
      end
      if (w_capture) begin
        r_prod <= mul_op_prod;
      end
    end
  end

  // Registered outputs decoded from the next state; overrun flag is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_mul_start <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tx_valid  <= (w_next == S_SEND_HI) || (w_next == S_SEND_LO);
      r_tx_data   <= w_tx_data;
      r_mul_start <= (w_next == S_START);
      r_busy      <= (w_next != S_GET_A);
      r_err       <= r_err | w_drop;
    end
  end

  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign mul_start   = r_mul_start;
  assign mul_ip_BA   = r_ba;
  assign busy        = r_busy;
  assign err_overrun = r_err;

endmodule
